// File: rtl/neuron_accumulator_if.sv
// rtl/neuron_accumulator_if.sv - operand, control and result signals of the neuron accumulator
interface neuron_accumulator_if #(
    parameter int Q_INT  = 8,
    parameter int Q_FRAC = 8,
    parameter int LEN_W  = 8,
    parameter int MASK_W = 2
);
    localparam int DW = Q_INT + Q_FRAC;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DW-1:0]     bias;
    logic [MASK_W-1:0] mask_in;
    logic              bypass_in;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_x;
    logic [DW-1:0]     in_w;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_x;
    logic [MASK_W-1:0] out_mask;
    logic              out_bypass;
    logic              out_sat;
    logic              busy;

    modport master (
        output start, len, bias, mask_in, bypass_in, in_valid, in_x, in_w, out_ready,
        input  in_ready, out_valid, out_x, out_mask, out_bypass, out_sat, busy
    );

    modport slave (
        input  start, len, bias, mask_in, bypass_in, in_valid, in_x, in_w, out_ready,
        output in_ready, out_valid, out_x, out_mask, out_bypass, out_sat, busy
    );
endinterface

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - fixed-point multiply-accumulate neuron with saturating result stage
// Define NEURON_ACC_ROUND_EN to round half up before the fraction shift; default truncates.
module neuron_accumulator #(
    parameter int Q_INT     = 8,
    parameter int Q_FRAC    = 8,
    parameter int LEN_W     = 8,
    parameter int ACC_GUARD = 8,
    parameter int MASK_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    neuron_accumulator_if.slave bus
);
    localparam int DW = Q_INT + Q_FRAC;
    localparam int PW = 2 * DW;
    localparam int AW = PW + ACC_GUARD;

    localparam logic signed [AW-1:0] RES_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] RES_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`ifdef NEURON_ACC_ROUND_EN
    localparam logic signed [AW-1:0] RND_K = AW'(1) <<< (Q_FRAC - 1);
`else
    localparam logic signed [AW-1:0] RND_K = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;
    state_t r_state, w_next;

    logic [LEN_W-1:0]     r_remain;
    logic signed [PW-1:0] r_prod;
    logic                 r_prod_vld;
    logic signed [AW-1:0] r_acc;
    logic [MASK_W-1:0]    r_mask;
    logic                 r_bypass;
    logic [DW-1:0]        r_stage_x;
    logic                 r_stage_sat;
    logic                 r_stage_vld;
    logic [DW-1:0]        r_out_x;
    logic [MASK_W-1:0]    r_out_mask;
    logic                 r_out_bypass;
    logic                 r_out_sat;

    logic                 w_in_ready;
    logic                 w_xfer;
    logic                 w_load_out;
    logic                 w_stage_en;
    logic signed [DW-1:0] w_x;
    logic signed [DW-1:0] w_w;
    logic signed [DW-1:0] w_bias;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_rnd;
    logic signed [AW-1:0] w_shift;
    logic [DW-1:0]        w_res_x;
    logic                 w_res_sat;

    assign w_x    = bus.in_x;
    assign w_w    = bus.in_w;
    assign w_bias = bus.bias;
    assign w_prod = PW'(w_x) * PW'(w_w);
    assign w_xfer = bus.in_valid && w_in_ready;

    // Result is staged one cycle ahead of the output register so the
    // round/shift/clamp path never feeds the handshake outputs directly.
    assign w_stage_en = (r_state == S_DRAIN) && !r_prod_vld && !r_stage_vld;

    always_comb begin
        w_rnd     = r_acc + RND_K;
        w_shift   = w_rnd >>> Q_FRAC;
        w_res_x   = w_shift[DW-1:0];
        w_res_sat = 1'b1;
        if (w_shift > RES_MAX) begin
            w_res_x = RES_MAX[DW-1:0];
        end else if (w_shift < RES_MIN) begin
            w_res_x = RES_MIN[DW-1:0];
        end else begin
            w_res_sat = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_load_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.len != '0) ? S_ACCUM : S_DRAIN;
                end
            end
            S_ACCUM: begin
                w_in_ready = (r_remain != '0);
                if (w_xfer && (r_remain == LEN_W'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_stage_vld) begin
                    w_load_out = 1'b1;
                    w_next     = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_remain     <= '0;
            r_prod       <= '0;
            r_prod_vld   <= 1'b0;
            r_acc        <= '0;
            r_mask       <= '0;
            r_bypass     <= 1'b0;
            r_stage_x    <= '0;
            r_stage_sat  <= 1'b0;
            r_stage_vld  <= 1'b0;
            r_out_x      <= '0;
            r_out_mask   <= '0;
            r_out_bypass <= 1'b0;
            r_out_sat    <= 1'b0;
        end else begin
            r_prod_vld <= w_xfer;
            if (w_xfer) begin
                r_prod   <= w_prod;
                r_remain <= r_remain - LEN_W'(1);
            end
            if (r_prod_vld) begin
                r_acc <= r_acc + AW'(r_prod);
            end
            if (w_stage_en) begin
                r_stage_x   <= w_res_x;
                r_stage_sat <= w_res_sat;
                r_stage_vld <= 1'b1;
            end
            if (w_load_out) begin
                r_out_x      <= r_stage_x;
                r_out_sat    <= r_stage_sat;
                r_out_mask   <= r_mask;
                r_out_bypass <= r_bypass;
                r_stage_vld  <= 1'b0;
            end
            // Bias enters the accumulator already aligned to the product's 2*Q_FRAC fraction.
            if ((r_state == S_IDLE) && bus.start) begin
                r_acc       <= AW'(w_bias) <<< Q_FRAC;
                r_remain    <= bus.len;
                r_mask      <= bus.mask_in;
                r_bypass    <= bus.bypass_in;
                r_prod_vld  <= 1'b0;
                r_stage_vld <= 1'b0;
                r_stage_sat <= 1'b0;
                r_out_sat   <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == S_OUT);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.out_x      = r_out_x;
    assign bus.out_mask   = r_out_mask;
    assign bus.out_bypass = r_out_bypass;
    assign bus.out_sat    = r_out_sat;
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - directed and randomized checks of neuron_accumulator against an arithmetic model
module tb_neuron_accumulator;
    localparam int Q_INT     = 8;
    localparam int Q_FRAC    = 8;
    localparam int LEN_W     = 8;
    localparam int ACC_GUARD = 8;
    localparam int MASK_W    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] q_x[$];
    logic [15:0] q_w[$];

    neuron_accumulator_if #(.Q_INT(Q_INT), .Q_FRAC(Q_FRAC), .LEN_W(LEN_W), .MASK_W(MASK_W)) bus ();

    neuron_accumulator #(
        .Q_INT(Q_INT), .Q_FRAC(Q_FRAC), .LEN_W(LEN_W), .ACC_GUARD(ACC_GUARD), .MASK_W(MASK_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Real-valued sum in units of 2^-16, floored (or rounded) back to 2^-8 and clamped.
    function automatic void model(input logic [15:0] bias, output logic [15:0] ex, output logic es);
        longint acc;
        longint res;
        acc = longint'($signed(bias)) * 256;
        foreach (q_x[i]) acc += longint'($signed(q_x[i])) * longint'($signed(q_w[i]));
`ifdef NEURON_ACC_ROUND_EN
        acc += 128;
`endif
        res = acc >>> 8;
        es  = 1'b0;
        if (res > 32767) begin
            res = 32767;
            es  = 1'b1;
        end else if (res < -32768) begin
            res = -32768;
            es  = 1'b1;
        end
        ex = 16'(res);
    endfunction

    task automatic feed_pair(input logic [15:0] x, input logic [15:0] w, input int gap);
        int waited;
        waited = 0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_w     = w;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_neuron(input string tag, input logic [15:0] bias, input logic [1:0] mask,
                              input logic byp, input int max_gap, input int hold, input bit junk);
        logic [15:0] ex;
        logic        es;
        int          lat;
        int          len;
        len = q_x.size();
        model(bias, ex, es);
        bus.start     = 1'b1;
        bus.len       = 8'(len);
        bus.bias      = bias;
        bus.mask_in   = mask;
        bus.bypass_in = byp;
        tick();
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.bias      = '0;
        bus.mask_in   = '0;
        bus.bypass_in = 1'b0;
        for (int i = 0; i < len; i++) feed_pair(q_x[i], q_w[i], $urandom_range(0, max_gap));
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 16'($urandom);
            bus.in_w     = 16'($urandom);
        end
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), (len == 0) ? 32'd2 : 32'd3);
        chk({tag, "_x"}, 32'(bus.out_x), 32'(ex));
        chk({tag, "_sat"}, 32'(bus.out_sat), 32'(es));
        chk({tag, "_mask"}, 32'(bus.out_mask), 32'(mask));
        chk({tag, "_bypass"}, 32'(bus.out_bypass), 32'(byp));
        for (int c = 0; c < hold; c++) begin
            bus.start = 1'b1;
            bus.len   = 8'($urandom_range(0, 5));
            bus.bias  = 16'($urandom);
            tick();
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_x"}, 32'(bus.out_x), 32'(ex));
            chk({tag, "_hold_mask"}, 32'(bus.out_mask), 32'(mask));
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
        q_x.delete();
        q_w.delete();
    endtask

    initial begin
        int lat;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.bias      = '0;
        bus.mask_in   = '0;
        bus.bypass_in = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_x", 32'(bus.out_x), 32'd0);
        chk("rst_out_mask", 32'(bus.out_mask), 32'd0);
        chk("rst_out_bypass", 32'(bus.out_bypass), 32'd0);
        chk("rst_out_sat", 32'(bus.out_sat), 32'd0);
        rst_n = 1'b1;
        tick();

        q_x = '{16'h0100, 16'hFE80, 16'h0040};
        q_w = '{16'h0200, 16'h0100, 16'h0040};
        run_neuron("basic", 16'h0080, 2'd1, 1'b0, 0, 1, 1'b0);
        chk("basic_const", 32'(bus.out_x), 32'h0110);

        q_x = '{16'h6400, 16'h6400};
        q_w = '{16'h6400, 16'h6400};
        run_neuron("sat_pos", 16'h0000, 2'd0, 1'b0, 0, 0, 1'b0);
        chk("sat_pos_const", 32'(bus.out_x), 32'h7FFF);

        q_x = '{16'h9C00, 16'h9C00};
        q_w = '{16'h6400, 16'h6400};
        run_neuron("sat_neg", 16'h0000, 2'd3, 1'b1, 1, 0, 1'b0);
        chk("sat_neg_const", 32'(bus.out_x), 32'h8000);

        q_x = '{16'h0001};
        q_w = '{16'h0080};
        run_neuron("round", 16'h0000, 2'd0, 1'b0, 0, 0, 1'b0);
`ifdef NEURON_ACC_ROUND_EN
        chk("round_const", 32'(bus.out_x), 32'h0001);
`else
        chk("round_const", 32'(bus.out_x), 32'h0000);
`endif

        run_neuron("len0", 16'hFF00, 2'd2, 1'b1, 0, 5, 1'b1);
        chk("len0_const", 32'(bus.out_x), 32'hFF00);

        // abandon a neuron after two of four pairs
        bus.start = 1'b1;
        bus.len   = 8'd4;
        bus.bias  = 16'h0300;
        tick();
        bus.start = 1'b0;
        feed_pair(16'h0200, 16'h0200, 0);
        feed_pair(16'h0100, 16'h0300, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_out_x", 32'(bus.out_x), 32'd0);
        chk("mid_rst_mask", 32'(bus.out_mask), 32'd0);
        chk("mid_rst_bypass", 32'(bus.out_bypass), 32'd0);
        repeat (6) tick();
        chk("mid_rst_quiet", 32'(bus.out_valid), 32'd0);
        q_x = '{16'h0100};
        q_w = '{16'h0100};
        run_neuron("after_rst", 16'h0000, 2'd0, 1'b0, 0, 0, 1'b0);
        chk("after_rst_const", 32'(bus.out_x), 32'h0100);

        // reset while a result is waiting in OUT
        bus.start    = 1'b1;
        bus.len      = 8'd0;
        bus.bias     = 16'h1234;
        bus.mask_in  = 2'd3;
        tick();
        bus.start    = 1'b0;
        bus.mask_in  = 2'd0;
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk("out_rst_pre_x", 32'(bus.out_x), 32'h1234);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        chk("out_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("out_rst_x", 32'(bus.out_x), 32'd0);
        chk("out_rst_mask", 32'(bus.out_mask), 32'd0);
        repeat (4) tick();
        chk("out_rst_quiet", 32'(bus.out_valid), 32'd0);

        for (int n = 0; n < 24; n++) begin
            int          len;
            bit          wide;
            logic [15:0] bias;
            len  = $urandom_range(0, 6);
            wide = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < len; i++) begin
                if (wide) begin
                    q_x.push_back(16'($urandom));
                    q_w.push_back(16'($urandom));
                end else begin
                    q_x.push_back(16'(int'($urandom_range(0, 4095)) - 2048));
                    q_w.push_back(16'(int'($urandom_range(0, 4095)) - 2048));
                end
            end
            bias = wide ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
            run_neuron("rnd", bias, 2'($urandom), 1'($urandom), 2, $urandom_range(0, 3), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
